// File: rtl/pipeline_exec_controller_if.sv
// Command, hazard and pipeline-control signals between the debug unit,
// the hazard unit and the execution sequencer.
interface pipeline_exec_controller_if #(
  parameter int CNT_W = 32
);
  logic             is_cmd_valid;
  logic [1:0]       i_cmd;
  logic             is_halt_in_ID;
  logic             is_load_use_stall;
  logic             os_pipe_enable;
  logic             os_PC_write;
  logic             os_write_IF_ID;
  logic             os_mux_control;
  logic             os_flush_IF_ID;
  logic             os_cmd_ready;
  logic             os_done;
  logic [2:0]       o_state;
  logic [CNT_W-1:0] o_cycle_count;

  // Handshake: a command transfers on a cycle where is_cmd_valid and
  // os_cmd_ready are both 1; a command offered while ready is 0 is dropped.
  modport master (
    output is_cmd_valid, i_cmd, is_halt_in_ID, is_load_use_stall,
    input  os_pipe_enable, os_PC_write, os_write_IF_ID, os_mux_control,
           os_flush_IF_ID, os_cmd_ready, os_done, o_state, o_cycle_count
  );

  modport slave (
    input  is_cmd_valid, i_cmd, is_halt_in_ID, is_load_use_stall,
    output os_pipe_enable, os_PC_write, os_write_IF_ID, os_mux_control,
           os_flush_IF_ID, os_cmd_ready, os_done, o_state, o_cycle_count
  );
endinterface

// File: rtl/pipeline_exec_controller.sv
// Execution sequencer: RUN/STEP/STOP gating of the pipeline enable, load-use
// stall merging, and HALT-triggered drain to a terminal DONE state.
module pipeline_exec_controller #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input logic                       i_clk,
  input logic                       i_rst,
  pipeline_exec_controller_if.slave bus
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    drain_cnt, drain_cnt_nxt;
  logic [CNT_W-1:0] cycle_count;
  logic             cmd_acc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_nxt;
      drain_cnt   <= drain_cnt_nxt;
      cycle_count <= cycle_count + {{(CNT_W-1){1'b0}}, bus.os_pipe_enable};
    end
  end

  always_comb begin
    state_nxt          = state;
    drain_cnt_nxt      = drain_cnt;
    bus.os_pipe_enable = 1'b0;
    bus.os_PC_write    = 1'b0;
    bus.os_write_IF_ID = 1'b0;
    bus.os_mux_control = 1'b0;
    bus.os_flush_IF_ID = 1'b0;
    bus.os_cmd_ready   = (state == IDLE) || (state == RUN);
    bus.os_done        = 1'b0;
    cmd_acc            = bus.is_cmd_valid && bus.os_cmd_ready;

    case (state)
      IDLE: begin
        if (cmd_acc && bus.i_cmd == CMD_RUN)  state_nxt = RUN;
        if (cmd_acc && bus.i_cmd == CMD_STEP) state_nxt = STEP;
      end
      RUN, STEP: begin
        bus.os_pipe_enable = 1'b1;
        // A STEP always returns to IDLE unless HALT sends it into a full drain.
        if (state == STEP) state_nxt = IDLE;
        else if (cmd_acc && bus.i_cmd == CMD_STOP) state_nxt = IDLE;
        if (bus.is_load_use_stall) begin
          bus.os_mux_control = 1'b1;
        end else if (bus.is_halt_in_ID) begin
          bus.os_write_IF_ID = 1'b1;
          bus.os_flush_IF_ID = 1'b1;
          state_nxt          = DRAIN;
          drain_cnt_nxt      = DW'(DRAIN_CYCLES - 1);
        end else begin
          bus.os_PC_write    = 1'b1;
          bus.os_write_IF_ID = 1'b1;
        end
      end
      DRAIN: begin
        bus.os_pipe_enable = 1'b1;
        bus.os_write_IF_ID = 1'b1;
        bus.os_flush_IF_ID = 1'b1;
        if (drain_cnt == '0) state_nxt = DONE;
        else drain_cnt_nxt = drain_cnt - DW'(1);
      end
      DONE: bus.os_done = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.o_state       = state;
  assign bus.o_cycle_count = cycle_count;
endmodule

// File: tb/tb_pipeline_exec_controller.sv
// Directed bench for pipeline_exec_controller: per-cycle expected outputs are
// queued by the driver and compared by a negedge monitor.
module tb_pipeline_exec_controller;
  localparam int CNT_W = 32;
  localparam int W     = 3 + 7 + CNT_W;

  localparam logic [1:0] NOP = 2'b00, RUNC = 2'b01, STEPC = 2'b10, STOPC = 2'b11;
  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_STEP = 3'd2,
                         S_DRAIN = 3'd3, S_DONE = 3'd4;
  // {pipe_enable, PC_write, write_IF_ID, mux_control, flush_IF_ID, cmd_ready, done}
  localparam logic [6:0] C_IDLE       = 7'b0000010;
  localparam logic [6:0] C_RUN_N      = 7'b1110010;
  localparam logic [6:0] C_STEP_N     = 7'b1110000;
  localparam logic [6:0] C_RUN_STALL  = 7'b1001010;
  localparam logic [6:0] C_STEP_STALL = 7'b1001000;
  localparam logic [6:0] C_RUN_HALT   = 7'b1010110;
  localparam logic [6:0] C_STEP_HALT  = 7'b1010100;
  localparam logic [6:0] C_DRAIN      = 7'b1010100;
  localparam logic [6:0] C_DONE       = 7'b0000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;

  pipeline_exec_controller_if #(.CNT_W(CNT_W)) bus ();

  pipeline_exec_controller #(.DRAIN_CYCLES(4), .CNT_W(CNT_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver: one task call = one clock cycle of stimulus
  task automatic cyc(input logic r, input logic v, input logic [1:0] c,
                     input logic h, input logic s, input logic chk,
                     input logic [2:0] st, input logic [6:0] ctl);
    @(posedge clk);
    #1;
    rst                   = r;
    bus.is_cmd_valid      = v;
    bus.i_cmd             = c;
    bus.is_halt_in_ID     = h;
    bus.is_load_use_stall = s;
    if (chk) exp_q.push_back({st, ctl, exp_cnt});
    if (r) exp_cnt = '0;
    else if (chk && ctl[6]) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic go(input logic v, input logic [1:0] c, input logic h,
                    input logic s, input logic [2:0] st, input logic [6:0] ctl);
    cyc(1'b0, v, c, h, s, 1'b1, st, ctl);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v, act_v;
      exp_v = exp_q.pop_front();
      act_v = {bus.o_state, bus.os_pipe_enable, bus.os_PC_write,
               bus.os_write_IF_ID, bus.os_mux_control, bus.os_flush_IF_ID,
               bus.os_cmd_ready, bus.os_done, bus.o_cycle_count};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t state/ctl/count got %0d/%b/%0d want %0d/%b/%0d",
                 $time, act_v[W-1 -: 3], act_v[CNT_W +: 7], act_v[CNT_W-1:0],
                 exp_v[W-1 -: 3], exp_v[CNT_W +: 7], exp_v[CNT_W-1:0]);
      end
    end
  end

  initial begin
    bus.is_cmd_valid      = 1'b0;
    bus.i_cmd             = NOP;
    bus.is_halt_in_ID     = 1'b0;
    bus.is_load_use_stall = 1'b0;

    // reset then idle
    cyc(1'b1, 0, NOP, 0, 0, 1'b0, S_IDLE, C_IDLE);
    cyc(1'b1, 0, NOP, 0, 0, 1'b0, S_IDLE, C_IDLE);
    for (int i = 0; i < 5; i++) go(0, NOP, 0, 0, S_IDLE, C_IDLE);
    go(1, STOPC, 0, 0, S_IDLE, C_IDLE);
    go(1, NOP,   0, 0, S_IDLE, C_IDLE);

    // three single steps; the second one has a RUN dropped during the step
    go(1, STEPC, 0, 0, S_IDLE, C_IDLE);
    go(0, NOP,   0, 0, S_STEP, C_STEP_N);
    go(0, NOP,   0, 0, S_IDLE, C_IDLE);
    go(1, STEPC, 0, 0, S_IDLE, C_IDLE);
    go(1, RUNC,  0, 0, S_STEP, C_STEP_N);
    go(0, NOP,   0, 0, S_IDLE, C_IDLE);
    go(1, STEPC, 0, 0, S_IDLE, C_IDLE);
    go(0, NOP,   0, 0, S_STEP, C_STEP_N);
    go(0, NOP,   0, 0, S_IDLE, C_IDLE);

    // a step consumed by a stall
    go(1, STEPC, 0, 0, S_IDLE, C_IDLE);
    go(0, NOP,   0, 1, S_STEP, C_STEP_STALL);
    go(0, NOP,   0, 0, S_IDLE, C_IDLE);

    // run with load-use stall, halt masked by stall, ignored RUN/STEP
    go(1, RUNC,  0, 0, S_IDLE, C_IDLE);
    go(0, NOP,   0, 0, S_RUN,  C_RUN_N);
    go(0, NOP,   0, 1, S_RUN,  C_RUN_STALL);
    go(0, NOP,   0, 0, S_RUN,  C_RUN_N);
    go(0, NOP,   1, 1, S_RUN,  C_RUN_STALL);
    go(1, RUNC,  0, 0, S_RUN,  C_RUN_N);
    go(1, STEPC, 0, 0, S_RUN,  C_RUN_N);

    // STOP, then resume
    go(1, STOPC, 0, 0, S_RUN,  C_RUN_N);
    go(0, NOP,   0, 0, S_IDLE, C_IDLE);
    go(1, RUNC,  0, 0, S_IDLE, C_IDLE);
    go(0, NOP,   0, 0, S_RUN,  C_RUN_N);

    // HALT beats STOP; drain ignores commands and hazards; DONE is terminal
    go(1, STOPC, 1, 0, S_RUN,   C_RUN_HALT);
    go(1, RUNC,  1, 1, S_DRAIN, C_DRAIN);
    go(0, NOP,   0, 1, S_DRAIN, C_DRAIN);
    go(1, STOPC, 1, 0, S_DRAIN, C_DRAIN);
    go(0, NOP,   0, 0, S_DRAIN, C_DRAIN);
    go(1, RUNC,  0, 0, S_DONE,  C_DONE);
    go(1, STEPC, 1, 0, S_DONE,  C_DONE);
    go(0, NOP,   0, 0, S_DONE,  C_DONE);

    // reset from DONE, run into HALT, reset during the second drain cycle
    cyc(1'b1, 0, NOP, 0, 0, 1'b1, S_DONE, C_DONE);
    go(0, NOP,   0, 0, S_IDLE,  C_IDLE);
    go(1, RUNC,  0, 0, S_IDLE,  C_IDLE);
    go(0, NOP,   0, 0, S_RUN,   C_RUN_N);
    go(0, NOP,   1, 0, S_RUN,   C_RUN_HALT);
    go(0, NOP,   0, 0, S_DRAIN, C_DRAIN);
    cyc(1'b1, 0, NOP, 0, 0, 1'b1, S_DRAIN, C_DRAIN);
    go(0, NOP,   0, 0, S_IDLE,  C_IDLE);

    // a STEP that hits HALT drains fully
    go(1, STEPC, 0, 0, S_IDLE,  C_IDLE);
    go(0, NOP,   1, 0, S_STEP,  C_STEP_HALT);
    for (int i = 0; i < 4; i++) go(0, NOP, 0, 0, S_DRAIN, C_DRAIN);
    go(0, NOP,   0, 0, S_DONE,  C_DONE);
    go(1, RUNC,  0, 0, S_DONE,  C_DONE);

    // let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_exec_controller.md
Name: pipeline_exec_controller

Overview:
Execution sequencer for the 5-stage MIPS pipeline. Takes RUN/STEP/STOP commands from the debug unit and gates the global pipeline enable. Merges the hazard unit's load-use stall into the PC and IF/ID write controls. On detecting HALT in ID, it stops fetch, drains in-flight instructions, and raises done.

Parameters:
DRAIN_CYCLES, 4, enabled cycles after HALT detection needed to retire the instructions ahead of HALT (EX, MEM, WB plus one margin).
CNT_W, 32, width of the executed-cycle counter.

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous, active-high reset
is_cmd_valid  input  1  command strobe, one cycle
i_cmd  input  2  00 NOP, 01 RUN, 10 STEP, 11 STOP
is_halt_in_ID  input  1  HALT opcode currently decoded in ID
is_load_use_stall  input  1  load-use hazard from hazard_unit (inverse of its o_PC_write)
os_pipe_enable  output  1  global enable for all pipeline registers
os_PC_write  output  1  PC update enable
os_write_IF_ID  output  1  IF/ID register write enable
os_mux_control  output  1  1 = insert bubble (zero control) into ID/EX
os_flush_IF_ID  output  1  1 = load NOP into IF/ID
os_cmd_ready  output  1  a command is accepted this cycle
os_done  output  1  program finished, pipeline drained
o_state  output  3  current state, for the debug unit: 0 IDLE, 1 RUN, 2 STEP, 3 DRAIN, 4 DONE
o_cycle_count  output  CNT_W  number of enabled cycles since reset

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high; it has priority over everything and is valid from any state, including mid-DRAIN.
- Reset values: state=IDLE, drain counter=0, o_cycle_count=0. In IDLE all control outputs are 0 except os_cmd_ready=1.
- State is registered. All outputs decode combinationally from the state and the current inputs.
- Command acceptance:
  - A command is accepted when is_cmd_valid=1 and os_cmd_ready=1.
  - os_cmd_ready=1 in IDLE and RUN, 0 in STEP, DRAIN and DONE.
  - Commands presented while not ready are dropped, not queued.
- IDLE:
  - RUN goes to RUN; STEP goes to STEP.
  - STOP and NOP: remain in IDLE. os_pipe_enable=0.
- RUN:
  - os_pipe_enable=1.
  - Accepted STOP goes to IDLE next cycle. The STOP cycle itself is still enabled.
  - RUN and STEP are ignored.
- STEP:
  - os_pipe_enable=1 for exactly one cycle, then IDLE.
- HALT detection (RUN or STEP, is_halt_in_ID=1, is_load_use_stall=0):
  - That cycle: os_PC_write=0 and os_flush_IF_ID=1.
  - Next state is DRAIN, with the drain counter loaded to DRAIN_CYCLES-1.
  - HALT beats a simultaneous STOP.
  - A STEP that hits HALT drains fully; the drain does not proceed step-by-step.
- Load-use stall (RUN or STEP, is_load_use_stall=1):
  - os_PC_write=0, os_write_IF_ID=0, os_mux_control=1.
  - is_halt_in_ID is masked that cycle.
  - A STEP consumed by a stall still counts as its one cycle.
- Normal enabled cycle: os_PC_write=1, os_write_IF_ID=1, os_mux_control=0, os_flush_IF_ID=0.
- DRAIN:
  - os_pipe_enable=1, os_PC_write=0, os_flush_IF_ID=1, os_write_IF_ID=1, os_mux_control=0.
  - The drain counter decrements each cycle. When it is 0, next state is DONE.
  - DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
  - Hazard and halt inputs are ignored.
- DONE:
  - os_done=1; os_pipe_enable, os_PC_write and os_write_IF_ID are 0.
  - DONE is terminal until reset.
- o_cycle_count:
  - Increments by 1 on every cycle with os_pipe_enable=1, including stall and drain cycles.
  - Wraps modulo 2^CNT_W.
- When os_pipe_enable=0, all write and flush controls are 0.

Test Plan:
- Reset then idle: assert i_rst 2 cycles, hold 5 cycles with no command -> o_state=0, os_pipe_enable=0, o_cycle_count=0, os_cmd_ready=1.
- STEP x3: three STEP commands separated by idle cycles -> each gives exactly one cycle of os_pipe_enable=1 with os_PC_write=1; o_cycle_count=3; state returns to 0 after each step.
- Load-use in RUN: RUN, then is_load_use_stall=1 for 1 cycle -> that cycle os_PC_write=0, os_write_IF_ID=0, os_mux_control=1, os_pipe_enable=1; following cycle os_PC_write=1.
- HALT drain: RUN, is_halt_in_ID=1 at cycle k -> cycle k os_PC_write=0 and os_flush_IF_ID=1; cycles k+1 to k+4 are DRAIN (o_state=3); os_done=1 from k+5; later RUN commands ignored; o_cycle_count equals enabled cycles through k+4.
- Simultaneous events:
  - STOP together with is_halt_in_ID -> DRAIN, not IDLE.
  - is_halt_in_ID together with is_load_use_stall -> stall outputs, state stays RUN.
  - STOP in RUN -> IDLE next cycle, and a later RUN resumes.
- Reset mid-DRAIN: assert i_rst during the second drain cycle -> next cycle o_state=0, o_cycle_count=0, os_done=0, os_cmd_ready=1.
